// File: rtl/fp_div_prenorm.sv
// ============================================================================
//  Module      : fp_div_prenorm
//  Description : Two-stage pre-normalisation for the floating-point divider.
//                Unpacks both operands, left-justifies the significands
//                (subnormals included) and forms the quotient sign and its
//                biased exponent. Define FP_DIV_PRENORM_SPECIAL_EN to build
//                zero/inf/NaN classification.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_div_prenorm #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int SH_W  = $clog2(MAN_W + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     dividend,
    input  logic [EXP_W+MAN_W:0]     divisor,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [MAN_W:0]           dividend_mantissa_normalized,
    output logic [MAN_W:0]           divisor_mantissa_normalized,
    output logic [SH_W-1:0]          dividend_shift,
    output logic [SH_W-1:0]          divisor_shift,
    output logic                     result_sign,
    output logic [EXP_W+1:0]         result_exponent,
    output logic                     out_nan,
    output logic                     out_inf,
    output logic                     out_zero
);

    localparam int OP_W = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int RE_W = EXP_W + 2;
    localparam logic [RE_W-1:0] c_BIAS = RE_W'((1 << (EXP_W - 1)) - 1);

    // Position of the leading one measured from the MSB; zero input gives 0.
    function automatic logic [SH_W-1:0] lzc(input logic [SIG_W-1:0] sig);
        lzc = '0;
        for (int i = 0; i < SIG_W; i++) begin
            if (sig[i]) lzc = SH_W'(SIG_W - 1 - i);
        end
    endfunction

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    logic             w_sign_a, w_sign_b;
    logic [EXP_W-1:0] w_exp_a, w_exp_b;
    logic [MAN_W-1:0] w_frac_a, w_frac_b;
    logic [SIG_W-1:0] w_sig_a, w_sig_b;
    logic [EXP_W-1:0] w_eff_a, w_eff_b;

    assign w_sign_a = dividend[OP_W-1];
    assign w_sign_b = divisor[OP_W-1];
    assign w_exp_a  = dividend[OP_W-2 -: EXP_W];
    assign w_exp_b  = divisor[OP_W-2 -: EXP_W];
    assign w_frac_a = dividend[MAN_W-1:0];
    assign w_frac_b = divisor[MAN_W-1:0];
    assign w_sig_a  = {(w_exp_a != '0), w_frac_a};
    assign w_sig_b  = {(w_exp_b != '0), w_frac_b};
    // Subnormals share the exponent of the smallest normal.
    assign w_eff_a  = (w_exp_a == '0) ? EXP_W'(1) : w_exp_a;
    assign w_eff_b  = (w_exp_b == '0) ? EXP_W'(1) : w_exp_b;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic r_s1_valid, r_s2_valid;
    logic w_s1_load, w_s2_load;

    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_s1_load = in_valid && in_ready;
    assign out_valid = r_s2_valid;

    // ------------------------------------------------------------------
    // Stage 1 / stage 2 data registers (intentionally not reset)
    // ------------------------------------------------------------------
    logic [SIG_W-1:0] r_s1_sig_a, r_s1_sig_b;
    logic [EXP_W-1:0] r_s1_eff_a, r_s1_eff_b;
    logic [SH_W-1:0]  r_s1_lz_a, r_s1_lz_b;
    logic             r_s1_sign;

    logic [SIG_W-1:0] r_s2_norm_a, r_s2_norm_b;
    logic [SH_W-1:0]  r_s2_sh_a, r_s2_sh_b;
    logic             r_s2_sign;
    logic [RE_W-1:0]  r_s2_exp;

    logic [SIG_W-1:0] w_norm_a, w_norm_b;
    logic [RE_W-1:0]  w_exp_q;

    assign w_norm_a = r_s1_sig_a << r_s1_lz_a;
    assign w_norm_b = r_s1_sig_b << r_s1_lz_b;
    // Modular arithmetic at RE_W bits yields the signed two's complement result.
    assign w_exp_q  = ({2'b00, r_s1_eff_a} - RE_W'(r_s1_lz_a))
                    - ({2'b00, r_s1_eff_b} - RE_W'(r_s1_lz_b))
                    + c_BIAS;

    always_ff @(posedge clk) begin
        if (w_s1_load) begin
            r_s1_sig_a <= w_sig_a;
            r_s1_sig_b <= w_sig_b;
            r_s1_eff_a <= w_eff_a;
            r_s1_eff_b <= w_eff_b;
            r_s1_lz_a  <= lzc(w_sig_a);
            r_s1_lz_b  <= lzc(w_sig_b);
            r_s1_sign  <= w_sign_a ^ w_sign_b;
        end
        if (w_s2_load) begin
            r_s2_norm_a <= w_norm_a;
            r_s2_norm_b <= w_norm_b;
            r_s2_sh_a   <= r_s1_lz_a;
            r_s2_sh_b   <= r_s1_lz_b;
            r_s2_sign   <= r_s1_sign;
            r_s2_exp    <= w_exp_q;
        end
    end

    assign dividend_mantissa_normalized = r_s2_norm_a;
    assign divisor_mantissa_normalized  = r_s2_norm_b;
    assign dividend_shift               = r_s2_sh_a;
    assign divisor_shift                = r_s2_sh_b;
    assign result_sign                  = r_s2_sign;
    assign result_exponent              = r_s2_exp;

    // ------------------------------------------------------------------
    // Valid bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_load)      r_s1_valid <= 1'b1;
            else if (w_s2_load) r_s1_valid <= 1'b0;

            if (w_s2_load)      r_s2_valid <= 1'b1;
            else if (out_ready) r_s2_valid <= 1'b0;
        end
    end

`ifdef FP_DIV_PRENORM_SPECIAL_EN
    // ------------------------------------------------------------------
    // Special-operand classification
    // ------------------------------------------------------------------
    logic w_zero_a, w_inf_a, w_nan_a;
    logic w_zero_b, w_inf_b, w_nan_b;
    logic r_s1_zero_a, r_s1_inf_a, r_s1_nan_a;
    logic r_s1_zero_b, r_s1_inf_b, r_s1_nan_b;
    logic w_nan_q, w_inf_q, w_zero_q;
    logic r_s2_nan, r_s2_inf, r_s2_zero;

    assign w_zero_a = (w_exp_a == '0) && (w_frac_a == '0);
    assign w_zero_b = (w_exp_b == '0) && (w_frac_b == '0);
    assign w_inf_a  = (&w_exp_a) && (w_frac_a == '0);
    assign w_inf_b  = (&w_exp_b) && (w_frac_b == '0);
    assign w_nan_a  = (&w_exp_a) && (w_frac_a != '0);
    assign w_nan_b  = (&w_exp_b) && (w_frac_b != '0);

    // 0/0 and inf/inf are invalid; NaN takes priority so the flags stay exclusive.
    assign w_nan_q  = r_s1_nan_a | r_s1_nan_b | (r_s1_zero_a & r_s1_zero_b)
                    | (r_s1_inf_a & r_s1_inf_b);
    assign w_inf_q  = !w_nan_q & (r_s1_inf_a | r_s1_zero_b);
    assign w_zero_q = !w_nan_q & (r_s1_zero_a | r_s1_inf_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_zero_a <= 1'b0;
            r_s1_inf_a  <= 1'b0;
            r_s1_nan_a  <= 1'b0;
            r_s1_zero_b <= 1'b0;
            r_s1_inf_b  <= 1'b0;
            r_s1_nan_b  <= 1'b0;
            r_s2_nan    <= 1'b0;
            r_s2_inf    <= 1'b0;
            r_s2_zero   <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_zero_a <= w_zero_a;
                r_s1_inf_a  <= w_inf_a;
                r_s1_nan_a  <= w_nan_a;
                r_s1_zero_b <= w_zero_b;
                r_s1_inf_b  <= w_inf_b;
                r_s1_nan_b  <= w_nan_b;
            end
            if (w_s2_load) begin
                r_s2_nan  <= w_nan_q;
                r_s2_inf  <= w_inf_q;
                r_s2_zero <= w_zero_q;
            end
        end
    end

    assign out_nan  = r_s2_nan;
    assign out_inf  = r_s2_inf;
    assign out_zero = r_s2_zero;
`else
    assign out_nan  = 1'b0;
    assign out_inf  = 1'b0;
    assign out_zero = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_div_prenorm.sv
// ============================================================================
//  Module      : tb_fp_div_prenorm
//  Description : Scoreboard bench for fp_div_prenorm (single precision).
//                Honours FP_DIV_PRENORM_SPECIAL_EN for the flag expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_div_prenorm;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SH_W  = 5;
`ifdef FP_DIV_PRENORM_SPECIAL_EN
    localparam bit c_SP = 1'b1;
`else
    localparam bit c_SP = 1'b0;
`endif

    typedef struct packed {
        logic [23:0] ma;
        logic [23:0] mb;
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic        sg;
        logic [9:0]  ex;
        logic        nan_f;
        logic        inf_f;
        logic        zero_f;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] dividend_mantissa_normalized;
    logic [23:0] divisor_mantissa_normalized;
    logic [4:0]  dividend_shift;
    logic [4:0]  divisor_shift;
    logic        result_sign;
    logic [9:0]  result_exponent;
    logic        out_nan;
    logic        out_inf;
    logic        out_zero;

    int   errors = 0;
    int   checks = 0;
    res_t sb[$];

    fp_div_prenorm #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SH_W(SH_W)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .in_valid                     (in_valid),
        .in_ready                     (in_ready),
        .dividend                     (dividend),
        .divisor                      (divisor),
        .out_valid                    (out_valid),
        .out_ready                    (out_ready),
        .dividend_mantissa_normalized (dividend_mantissa_normalized),
        .divisor_mantissa_normalized  (divisor_mantissa_normalized),
        .dividend_shift               (dividend_shift),
        .divisor_shift                (divisor_shift),
        .result_sign                  (result_sign),
        .result_exponent              (result_exponent),
        .out_nan                      (out_nan),
        .out_inf                      (out_inf),
        .out_zero                     (out_zero)
    );

    always #5 clk = ~clk;

    function automatic res_t mk(input logic [23:0] ma, input logic [23:0] mb,
                                input logic [4:0] sa, input logic [4:0] sbb,
                                input logic sg, input logic [9:0] ex,
                                input logic n, input logic i, input logic z);
        mk = {ma, mb, sa, sbb, sg, ex, n & c_SP, i & c_SP, z & c_SP};
    endfunction

    // Reference: normalise by repeated doubling.
    function automatic void unpack(input logic [31:0] x, output logic [23:0] m,
                                   output int sh, output int e);
        m  = {(x[30:23] != 8'd0), x[22:0]};
        e  = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
        sh = 0;
        if (m != 24'd0) begin
            while (m[23] == 1'b0) begin
                m  = m << 1;
                sh = sh + 1;
            end
        end
    endfunction

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        logic [23:0] ma, mb;
        int sha, shb, ea, eb, ex;
        logic za, zb, ia, ib, na, nb, n;
        unpack(a, ma, sha, ea);
        unpack(b, mb, shb, eb);
        ex = (ea - sha) - (eb - shb) + 127;
        za = (a[30:0] == 31'd0);
        zb = (b[30:0] == 31'd0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        n  = na | nb | (za & zb) | (ia & ib);
        model = mk(ma, mb, 5'(sha), 5'(shb), a[31] ^ b[31], ex[9:0],
                   n, !n & (ia | zb), !n & (za | ib));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: pops on every output transfer.
    always @(negedge clk) begin
        res_t got, e;
        if (!rst && out_valid && out_ready) begin
            got = {dividend_mantissa_normalized, divisor_mantissa_normalized,
                   dividend_shift, divisor_shift, result_sign, result_exponent,
                   out_nan, out_inf, out_zero};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h with empty scoreboard", got);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL result: got ma=%h mb=%h sa=%0d sb=%0d s=%b ex=%h n/i/z=%b%b%b expected ma=%h mb=%h sa=%0d sb=%0d s=%b ex=%h n/i/z=%b%b%b",
                             got.ma, got.mb, got.sa, got.sb, got.sg, got.ex,
                             got.nan_f, got.inf_f, got.zero_f,
                             e.ma, e.mb, e.sa, e.sb, e.sg, e.ex,
                             e.nan_f, e.inf_f, e.zero_f);
                end
            end
        end
    end

    logic [31:0] va [7];
    logic [31:0] vb [7];
    res_t        ve [7];

    // Presents one pair; returns once accepted (edge + 1) and reports edges taken.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input res_t e,
                        output int tries);
        bit ok, acc;
        ok = 1'b0;
        tries = 0;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
            if (acc) begin
                sb.push_back(e);
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic lat_test(input int idx, input string name);
        int t;
        send(va[idx], vb[idx], ve[idx], t);
        chk({name, "_valid_n1"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk({name, "_valid_n2"}, 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int t, stalls, acc_cnt, idx;
        bit r;
        logic [31:0] ra, rb;

        va[0] = 32'h40C00000; vb[0] = 32'h40400000;
        ve[0] = mk(24'hC00000, 24'hC00000, 5'd0, 5'd0, 1'b0, 10'h080, 0, 0, 0);
        va[1] = 32'h00000001; vb[1] = 32'h3F800000;
        ve[1] = mk(24'h800000, 24'h800000, 5'd23, 5'd0, 1'b0, 10'h3EA, 0, 0, 0);
        va[2] = 32'hC0000000; vb[2] = 32'h3F800000;
        ve[2] = mk(24'h800000, 24'h800000, 5'd0, 5'd0, 1'b1, 10'h080, 0, 0, 0);
        va[3] = 32'h3F800000; vb[3] = 32'h00400000;
        ve[3] = mk(24'h800000, 24'h800000, 5'd0, 5'd1, 1'b0, 10'h0FE, 0, 0, 0);
        va[4] = 32'h7F800000; vb[4] = 32'h00000000;
        ve[4] = mk(24'h800000, 24'h000000, 5'd0, 5'd0, 1'b0, 10'h17D, 0, 1, 0);
        va[5] = 32'h00000000; vb[5] = 32'h00000000;
        ve[5] = mk(24'h000000, 24'h000000, 5'd0, 5'd0, 1'b0, 10'h07F, 1, 0, 0);
        va[6] = 32'h3F800000; vb[6] = 32'h7F800000;
        ve[6] = mk(24'h800000, 24'h800000, 5'd0, 5'd0, 1'b0, 10'h3FF, 0, 0, 1);

        rst = 1'b1;
        in_valid = 1'b0;
        dividend = '0;
        divisor = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_flags", {29'd0, out_nan, out_inf, out_zero}, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Normal operand pair with latency check, then directed vectors back to back.
        lat_test(0, "normal");
        for (int i = 1; i < 7; i++) send(va[i], vb[i], ve[i], t);
        drain("directed_drain");

        // Back-to-back stream.
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) begin
                ra = va[2];
                rb = vb[2];
            end else begin
                ra = $urandom;
                rb = $urandom;
            end
            send(ra, rb, (i == 50) ? ve[2] : model(ra, rb), t);
            if (t != 1) stalls++;
        end
        chk("stream_stalls", 32'(stalls), 32'd0);
        drain("stream_drain");

        // Backpressure: five cycles of out_ready low with in_valid held.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc_cnt   = 0;
        idx       = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            dividend = va[idx];
            divisor  = vb[idx];
            r = in_ready;
            if (cyc == 3) chk("bp_in_ready_c3", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            if (r) begin
                sb.push_back(ve[idx]);
                idx++;
                acc_cnt++;
            end
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc_cnt), 32'd2);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_ex", 32'(result_exponent), 32'(ve[0].ex));
        chk("bp_hold_ma", 32'(dividend_mantissa_normalized), 32'(ve[0].ma));
        out_ready = 1'b1;
        drain("bp_drain");

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(va[3], vb[3], ve[3], t);
        send(va[4], vb[4], ve[4], t);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_flags", {29'd0, out_nan, out_inf, out_zero}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("midrst_empty", 32'(out_valid), 32'd0);
        lat_test(6, "post_rst");
        drain("final_drain");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
